goldschmidt_ctrl: RTL and testbench
===================================

# goldschmidt_ctrl

Sequencing controller for the Goldschmidt divider datapath. It accepts a divide request with a start/busy/done handshake and latches the N, D and IA operands, holding them stable on the datapath inputs. It then drives the datapath's load and mux selects through the IA·D, IA·N and K·D/K·N refinement cycles, and registers the final quotient from the datapath's result.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- ITERS, 4, number of K refinement pairs (K·D then K·N); legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- n_in  in  WIDTH  numerator
- d_in  in  WIDTH  denominator
- ia_in  in  WIDTH  initial reciprocal approximation
- result_in  in  WIDTH  datapath result
- N  out  WIDTH  latched numerator to datapath
- D  out  WIDTH  latched denominator to datapath
- IA  out  WIDTH  latched approximation to datapath
- load_regN  out  1  datapath N-register load
- load_regD  out  1  datapath D-register load
- sel_ND_mux  out  2  datapath operand select
- sel_K_mux  out  1  1 = IA, 0 = K
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- q_out  out  WIDTH  registered quotient

## Operation
- States: IDLE, IA_D, IA_N, K_D, K_N, CAPT.
- Controls are Moore outputs decoded from the state register only.
  - IDLE: loadN=0, loadD=0, sel_ND=00, sel_K=1
  - IA_D: loadD=1, loadN=0, sel_ND=00, sel_K=1
  - IA_N: loadN=1, loadD=0, sel_ND=01, sel_K=1
  - K_D: loadD=1, loadN=0, sel_ND=10, sel_K=0
  - K_N: loadN=1, loadD=0, sel_ND=11, sel_K=0
  - CAPT: loads 0, sel_ND=11, sel_K=0
- Transitions:
  - IDLE→IA_D when start=1; n_in, d_in and ia_in are latched into N, D, IA on the same edge.
  - IA_D→IA_N→K_D.
  - K_D→K_N.
  - K_N→K_D while iter_cnt < ITERS-1, incrementing iter_cnt; otherwise K_N→CAPT.
  - CAPT→IDLE; q_out<=result_in and done<=1 on that edge.
- iter_cnt is a 4-bit counter, cleared on IDLE→IA_D.
- N, D and IA change only on an accepted start.
- q_out holds its value until the next CAPT.
- busy=1 in every state except IDLE.
- start while busy is ignored; it is neither queued nor counted.
- No arithmetic in this block; widths pass through unchanged.

## Timing
- All outputs reset to 0, except sel_K_mux=1 (IDLE decode). State resets to IDLE, iter_cnt=0.
- Start sampled at edge 0:
  - IA_D is cycle 1, IA_N is cycle 2.
  - K_D/K_N occupy cycles 3..2+2·ITERS.
  - CAPT is cycle 3+2·ITERS.
  - done=1 and q_out is valid in cycle 4+2·ITERS (12 for ITERS=4).
- done is high for exactly one cycle. busy falls in the same cycle that done rises.
- Back-to-back: start high in the done cycle is accepted, and IA_D follows in the next cycle.
- Reset mid-operation: on the next edge, return to IDLE with all outputs at reset values, including q_out=0 and done=0. No done pulse for the aborted operation.
- Reset and start asserted together: reset wins.

## Structure
- Shared package goldschmidt_pkg:
  - state enum
  - sel_ND encodings: SEL_IA_D=2'b00, SEL_IA_N=2'b01, SEL_K_D=2'b10, SEL_K_N=2'b11
  - SEL_K_IA=1'b1, SEL_K_K=1'b0
  - default WIDTH
- Single module; no sub-module is warranted. State register, counter, operand latches and output decode all live in goldschmidt_ctrl.

## Test plan
- Nominal, ITERS=4: start with n_in=16'h85E5, d_in=16'hFDD7, ia_in=16'h8000.
  - Per-cycle (loadN, loadD, sel_ND, sel_K) must be: (0,1,00,1), (1,0,01,1), then (0,1,10,0)/(1,0,11,0) ×4, then CAPT.
  - done must pulse in cycle 12.
  - q_out must equal the result_in value 16'hA7F5 driven during CAPT.
- Operand stability: change n_in, d_in and ia_in every cycle after start → N, D, IA must stay 16'h85E5, 16'hFDD7, 16'h8000 until the next accepted start.
- Start while busy: pulse start in cycles 3 and 7 → no restart, done still in cycle 12, exactly one done pulse.
- Back-to-back: start held high continuously → done every 12 cycles, and IA_D decode must follow each done cycle.
- Reset mid-operation: assert reset in cycle 5 of an operation → next cycle in IDLE, all outputs at reset values (sel_K_mux=1), q_out=0, and no done pulse afterwards.
- ITERS=1 build: start → done in cycle 6, with exactly one K_D/K_N pair.

Source files
------------

// File: rtl/goldschmidt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : goldschmidt_pkg
//  Description : Shared types and encodings for the Goldschmidt divider
//                sequencing controller (state enum, datapath mux selects).
//  Revision    : 1.0 - initial release
// ============================================================================
package goldschmidt_pkg;

    // Default operand/result width of the divider datapath
    localparam int DEFAULT_WIDTH = 16;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IA_D = 3'd1,
        ST_IA_N = 3'd2,
        ST_K_D  = 3'd3,
        ST_K_N  = 3'd4,
        ST_CAPT = 3'd5
    } state_t;

    // Datapath operand select (sel_ND_mux)
    localparam logic [1:0] SEL_IA_D = 2'b00;
    localparam logic [1:0] SEL_IA_N = 2'b01;
    localparam logic [1:0] SEL_K_D  = 2'b10;
    localparam logic [1:0] SEL_K_N  = 2'b11;

    // Multiplier factor select (sel_K_mux)
    localparam logic SEL_K_IA = 1'b1;
    localparam logic SEL_K_K  = 1'b0;

endpackage : goldschmidt_pkg
`default_nettype wire

// File: rtl/goldschmidt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : goldschmidt_ctrl
//  Description : Sequencing controller for the Goldschmidt divider. Latches
//                N/D/IA on an accepted start, steps the datapath through the
//                IA*D, IA*N and ITERS K*D/K*N refinement pairs, then registers
//                the quotient and pulses done for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module goldschmidt_ctrl
    import goldschmidt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITERS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] ia_in,
    input  logic [WIDTH-1:0] result_in,
    output logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] IA,
    output logic             load_regN,
    output logic             load_regD,
    output logic [1:0]       sel_ND_mux,
    output logic             sel_K_mux,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_out
);

    // Last value of iter_cnt before leaving the refinement loop
    localparam logic [3:0] c_last_iter = 4'(ITERS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_iter_cnt;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_ia;
    logic [WIDTH-1:0] r_q;
    logic             r_done;
    logic             w_accept;
    logic             w_more_iters;

    // Start is only honoured from IDLE; requests while busy are dropped
    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_more_iters = (r_iter_cnt < c_last_iter);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and Moore decode of the datapath controls
    always_comb begin
        w_next_state = r_state;
        load_regN    = 1'b0;
        load_regD    = 1'b0;
        sel_ND_mux   = SEL_IA_D;
        sel_K_mux    = SEL_K_IA;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = ST_IA_D;
                end
            end
            ST_IA_D: begin
                load_regD    = 1'b1;
                w_next_state = ST_IA_N;
            end
            ST_IA_N: begin
                load_regN    = 1'b1;
                sel_ND_mux   = SEL_IA_N;
                w_next_state = ST_K_D;
            end
            ST_K_D: begin
                load_regD    = 1'b1;
                sel_ND_mux   = SEL_K_D;
                sel_K_mux    = SEL_K_K;
                w_next_state = ST_K_N;
            end
            ST_K_N: begin
                load_regN    = 1'b1;
                sel_ND_mux   = SEL_K_N;
                sel_K_mux    = SEL_K_K;
                w_next_state = w_more_iters ? ST_K_D : ST_CAPT;
            end
            ST_CAPT: begin
                sel_ND_mux   = SEL_K_N;
                sel_K_mux    = SEL_K_K;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Refinement-pair counter: cleared on accept, stepped on each K_N->K_D loop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iter_cnt <= 4'd0;
        end else if (w_accept) begin
            r_iter_cnt <= 4'd0;
        end else if (r_state == ST_K_N && w_more_iters) begin
            r_iter_cnt <= r_iter_cnt + 4'd1;
        end
    end

    // Operand latches: held stable for the datapath until the next accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n  <= '0;
            r_d  <= '0;
            r_ia <= '0;
        end else if (w_accept) begin
            r_n  <= n_in;
            r_d  <= d_in;
            r_ia <= ia_in;
        end
    end

    // Quotient capture and one-cycle done pulse on leaving CAPT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_CAPT);
            if (r_state == ST_CAPT) begin
                r_q <= result_in;
            end
        end
    end

    assign N     = r_n;
    assign D     = r_d;
    assign IA    = r_ia;
    assign q_out = r_q;
    assign done  = r_done;

endmodule : goldschmidt_ctrl
`default_nettype wire

// File: tb/tb_goldschmidt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_goldschmidt_ctrl
//  Description : Directed self-checking bench for goldschmidt_ctrl; exercises
//                an ITERS=4 instance and an ITERS=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_goldschmidt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start4;
    logic        start1;
    logic [15:0] n_in;
    logic [15:0] d_in;
    logic [15:0] ia_in;
    logic [15:0] result_in;

    logic [15:0] n4, d4, ia4, q4;
    logic        ln4, ld4, sk4, busy4, done4;
    logic [1:0]  snd4;
    logic [15:0] n1, d1, ia1, q1;
    logic        ln1, ld1, sk1, busy1, done1;
    logic [1:0]  snd1;

    int checks = 0;
    int errors = 0;

    goldschmidt_ctrl #(.WIDTH(16), .ITERS(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .n_in(n_in), .d_in(d_in), .ia_in(ia_in), .result_in(result_in),
        .N(n4), .D(d4), .IA(ia4),
        .load_regN(ln4), .load_regD(ld4), .sel_ND_mux(snd4), .sel_K_mux(sk4),
        .busy(busy4), .done(done4), .q_out(q4)
    );

    goldschmidt_ctrl #(.WIDTH(16), .ITERS(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .n_in(n_in), .d_in(d_in), .ia_in(ia_in), .result_in(result_in),
        .N(n1), .D(d1), .IA(ia1),
        .load_regN(ln1), .load_regD(ld1), .sel_ND_mux(snd1), .sel_K_mux(sk1),
        .busy(busy1), .done(done1), .q_out(q1)
    );

    always #5 clk = ~clk;

    // Advance one clock; observe and drive 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {loadN, loadD, sel_ND, sel_K, busy} in cycle c after the start edge
    function automatic logic [5:0] exp_ctrl(input int c, input int it);
        if (c == 1)                          return 6'b01_00_1_1;
        else if (c == 2)                     return 6'b10_01_1_1;
        else if (c <= 2 + 2 * it && c[0])    return 6'b01_10_0_1;
        else if (c <= 2 + 2 * it)            return 6'b10_11_0_1;
        else if (c == 3 + 2 * it)            return 6'b00_11_0_1;
        else                                 return 6'b00_00_1_0;
    endfunction

    function automatic logic [5:0] obs_ctrl(input bit use1);
        if (use1) return {ln1, ld1, snd1, sk1, busy1};
        else      return {ln4, ld4, snd4, sk4, busy4};
    endfunction

    // One operation: start on the next edge, then check cycles 1..done cycle.
    // Leaves the simulation in the done cycle without advancing past it.
    task automatic run_op(input bit use1, input int it,
                          input logic [15:0] n, input logic [15:0] d,
                          input logic [15:0] ia, input logic [15:0] res,
                          input bit pulse_busy, input bit hold);
        int last;
        last      = 4 + 2 * it;
        n_in      = n;
        d_in      = d;
        ia_in     = ia;
        result_in = 16'h1234;
        if (use1) start1 = 1'b1; else start4 = 1'b1;
        tick();
        if (!hold) begin
            start1 = 1'b0;
            start4 = 1'b0;
        end
        for (int c = 1; c <= last; c++) begin
            check($sformatf("ctrl c%0d", c), {26'd0, obs_ctrl(use1)}, {26'd0, exp_ctrl(c, it)});
            check($sformatf("done c%0d", c), {31'd0, (use1 ? done1 : done4)}, {31'd0, (c == last)});
            check($sformatf("N c%0d", c),  {16'd0, (use1 ? n1 : n4)},   {16'd0, n});
            check($sformatf("D c%0d", c),  {16'd0, (use1 ? d1 : d4)},   {16'd0, d});
            check($sformatf("IA c%0d", c), {16'd0, (use1 ? ia1 : ia4)}, {16'd0, ia});
            if (c == last) begin
                check("q_out", {16'd0, (use1 ? q1 : q4)}, {16'd0, res});
            end else begin
                n_in      = n ^ 16'(c * 16'h0101);
                d_in      = d ^ 16'(c * 16'h0303);
                ia_in     = ia ^ 16'(c * 16'h0707);
                result_in = (c == 3 + 2 * it) ? res : (16'h1234 ^ 16'(c));
                if (pulse_busy) begin
                    start4 = (c == 3) || (c == 7);
                end
                tick();
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start4    = 1'b0;
        start1    = 1'b0;
        n_in      = 16'h0;
        d_in      = 16'h0;
        ia_in     = 16'h0;
        result_in = 16'h0;
        tick();
        start4 = 1'b1;          // reset must win over start
        tick();
        start4 = 1'b0;

        // Reset state
        check("rst ctrl",  {26'd0, obs_ctrl(1'b0)}, {26'd0, 6'b00_00_1_0});
        check("rst done",  {31'd0, done4}, 32'd0);
        check("rst N/D/IA", {n4, d4 | ia4}, 32'd0);
        check("rst q_out", {16'd0, q4}, 32'd0);

        reset = 1'b0;
        tick();
        check("idle busy", {31'd0, busy4}, 32'd0);

        // Nominal ITERS=4 with operand perturbation
        run_op(1'b0, 4, 16'h85E5, 16'hFDD7, 16'h8000, 16'hA7F5, 1'b0, 1'b0);
        tick();
        check("post done", {31'd0, done4}, 32'd0);
        check("post busy", {31'd0, busy4}, 32'd0);
        check("post N", {16'd0, n4}, {16'd0, 16'h85E5});

        // Start pulses while busy must be ignored
        run_op(1'b0, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4C4C, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) begin
            tick();
            check($sformatf("nodup done k%0d", k), {31'd0, done4}, 32'd0);
            check($sformatf("nodup busy k%0d", k), {31'd0, busy4}, 32'd0);
        end

        // Back-to-back with start held high
        run_op(1'b0, 4, 16'hAAAA, 16'h5555, 16'h0F0F, 16'h6001, 1'b0, 1'b1);
        run_op(1'b0, 4, 16'hBEEF, 16'hCAFE, 16'h7777, 16'h6002, 1'b0, 1'b1);
        run_op(1'b0, 4, 16'h0123, 16'h4567, 16'h89AB, 16'h6003, 1'b0, 1'b0);
        tick();
        check("b2b end busy", {31'd0, busy4}, 32'd0);

        // Reset in cycle 5 of an operation
        n_in   = 16'h9999;
        d_in   = 16'h8888;
        ia_in  = 16'h7777;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre-rst busy", {31'd0, busy4}, 32'd1);
        reset = 1'b1;
        tick();
        check("midrst ctrl", {26'd0, obs_ctrl(1'b0)}, {26'd0, 6'b00_00_1_0});
        check("midrst done", {31'd0, done4}, 32'd0);
        check("midrst q_out", {16'd0, q4}, 32'd0);
        check("midrst N/D/IA", {n4, d4 | ia4}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            check($sformatf("aborted done k%0d", k), {31'd0, done4}, 32'd0);
            check($sformatf("aborted busy k%0d", k), {31'd0, busy4}, 32'd0);
        end

        // ITERS=1 instance
        run_op(1'b1, 1, 16'h4321, 16'h8765, 16'hC000, 16'h3C3C, 1'b0, 1'b0);
        tick();
        check("it1 post done", {31'd0, done1}, 32'd0);
        check("it1 post busy", {31'd0, busy1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_goldschmidt_ctrl
`default_nettype wire
